// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run sequencer: FSM state encoding.
package run_sequencer_pkg;

  typedef enum logic [2:0] {
    RS_IDLE  = 3'd0,
    RS_INIT  = 3'd1,
    RS_START = 3'd2,
    RS_RUN   = 3'd3,
    RS_DONE  = 3'd4,
    RS_FAULT = 3'd5
  } run_state_t;

endpackage

// File: rtl/run_sequencer.sv
// Host-side run controller: initialises the core, pulses req once per run,
// times each run until ack, re-initialises between runs, and guards every
// run with a watchdog. All outputs are registered from the next state.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int CW       = 16,
  parameter int RW       = 4,
  parameter int INIT_CYC = 2,
  parameter int TIMEOUT  = 4096
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          host_start,
  input  logic [RW-1:0] host_runs,
  input  logic          host_abort,
  input  logic          host_clear,
  input  logic          core_ack,
  output logic          core_init,
  output logic          core_req,
  output logic          busy,
  output logic          done,
  output logic          fault,
  output logic [RW-1:0] runs_done,
  output logic [CW-1:0] last_cycles,
  output logic [CW-1:0] total_cycles
);

  // Init counter only needs to reach INIT_CYC-1.
  localparam int ICW = (INIT_CYC < 2) ? 1 : $clog2(INIT_CYC);

  run_state_t    state_q, state_d;
  logic [RW-1:0] target_q, target_d;
  logic [RW-1:0] runs_done_q, runs_done_d;
  logic [ICW-1:0] init_cnt_q, init_cnt_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic [CW-1:0] last_q, last_d;
  logic [CW-1:0] total_q, total_d;
  logic          core_init_q, core_init_d;
  logic          core_req_q, core_req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;

  // Cycles of the current run including this one, and the widened sum used
  // for saturation of the running total.
  logic [CW-1:0] run_cnt_inc;
  logic [CW:0]   total_sum;
  logic [RW-1:0] runs_done_inc;

  assign run_cnt_inc   = run_cnt_q + CW'(1);
  assign total_sum     = {1'b0, total_q} + {1'b0, run_cnt_inc};
  assign runs_done_inc = runs_done_q + RW'(1);

  // Next-state and counter updates; abort has priority over everything in
  // the busy states, start has priority over clear in the parked states.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    runs_done_d = runs_done_q;
    init_cnt_d  = init_cnt_q;
    run_cnt_d   = run_cnt_q;
    last_d      = last_q;
    total_d     = total_q;
    case (state_q)
      RS_IDLE, RS_DONE, RS_FAULT: begin
        if (host_start) begin
          target_d    = host_runs;
          runs_done_d = '0;
          last_d      = '0;
          total_d     = '0;
          init_cnt_d  = '0;
          state_d     = (host_runs == '0) ? RS_DONE : RS_INIT;
        end else if (host_clear) begin
          state_d = RS_IDLE;
        end
      end
      RS_INIT: begin
        if (host_abort) begin
          state_d = RS_IDLE;
        end else if (init_cnt_q == ICW'(INIT_CYC - 1)) begin
          state_d = RS_START;
        end else begin
          init_cnt_d = init_cnt_q + ICW'(1);
        end
      end
      RS_START: begin
        if (host_abort) begin
          state_d = RS_IDLE;
        end else begin
          run_cnt_d = '0;
          state_d   = RS_RUN;
        end
      end
      RS_RUN: begin
        if (host_abort) begin
          state_d = RS_IDLE;
        end else if (core_ack) begin
          // Ack on the watchdog's last cycle still counts as a completion.
          last_d      = run_cnt_inc;
          total_d     = total_sum[CW] ? {CW{1'b1}} : total_sum[CW-1:0];
          runs_done_d = runs_done_inc;
          init_cnt_d  = '0;
          state_d     = (runs_done_inc == target_q) ? RS_DONE : RS_INIT;
        end else if (run_cnt_inc == CW'(TIMEOUT)) begin
          state_d = RS_FAULT;
        end else begin
          run_cnt_d = run_cnt_inc;
        end
      end
      default: state_d = RS_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so they line up with it.
  always_comb begin
    core_init_d = !((state_d == RS_START) || (state_d == RS_RUN));
    core_req_d  = (state_d == RS_START);
    busy_d      = (state_d == RS_INIT) || (state_d == RS_START) || (state_d == RS_RUN);
    done_d      = (state_d == RS_DONE);
    fault_d     = (state_d == RS_FAULT);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= RS_IDLE;
      target_q    <= '0;
      runs_done_q <= '0;
      init_cnt_q  <= '0;
      run_cnt_q   <= '0;
      last_q      <= '0;
      total_q     <= '0;
      core_init_q <= 1'b1;
      core_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      runs_done_q <= runs_done_d;
      init_cnt_q  <= init_cnt_d;
      run_cnt_q   <= run_cnt_d;
      last_q      <= last_d;
      total_q     <= total_d;
      core_init_q <= core_init_d;
      core_req_q  <= core_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign core_init    = core_init_q;
  assign core_req     = core_req_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fault        = fault_q;
  assign runs_done    = runs_done_q;
  assign last_cycles  = last_q;
  assign total_cycles = total_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: reset, single/multi run, watchdog,
// ack on the watchdog boundary, abort, stale ack and mid-run reset.
`timescale 1ns/1ps
module tb_run_sequencer;

  localparam int CW = 16;
  localparam int RW = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          host_start = 1'b0;
  logic [RW-1:0] host_runs = '0;
  logic          host_abort = 1'b0;
  logic          host_clear = 1'b0;
  logic          core_ack = 1'b0;
  logic          core_init, core_req, busy, done, fault;
  logic [RW-1:0] runs_done;
  logic [CW-1:0] last_cycles, total_cycles;

  int checks = 0;
  int errors = 0;

  run_sequencer #(.CW(CW), .RW(RW), .INIT_CYC(2), .TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .host_start(host_start), .host_runs(host_runs),
    .host_abort(host_abort), .host_clear(host_clear),
    .core_ack(core_ack), .core_init(core_init), .core_req(core_req),
    .busy(busy), .done(done), .fault(fault), .runs_done(runs_done),
    .last_cycles(last_cycles), .total_cycles(total_cycles)
  );

  always #5 Clk = ~Clk;

  // {core_init, core_req, busy, done, fault}
  logic [4:0] flags;
  assign flags = {core_init, core_req, busy, done, fault};

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Host start pulse for one cycle; afterwards we sit in the first INIT cycle.
  task automatic kick(input logic [RW-1:0] runs);
    host_runs  = runs;
    host_start = 1'b1;
    step();
    host_start = 1'b0;
  endtask

  // From the first INIT cycle, expect req exactly INIT_CYC cycles later.
  task automatic wait_req(input string tag);
    step();
    checks++;
    if (core_req !== 1'b0 || core_init !== 1'b1) begin
      errors++;
      $display("FAIL %s_init2: req=%b init=%b, want req=0 init=1", tag, core_req, core_init);
    end
    step();
    checks++;
    if (core_req !== 1'b1 || core_init !== 1'b0) begin
      errors++;
      $display("FAIL %s_req: req=%b init=%b, want req=1 init=0", tag, core_req, core_init);
    end
  endtask

  // From the req cycle, raise ack in the delay-th RUN cycle.
  task automatic finish_run(input string tag, input int delay);
    for (int i = 0; i < delay; i++) begin
      step();
      if (i == 0) begin
        checks++;
        if (core_req !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s_pulse: req=%b busy=%b, want req=0 busy=1", tag, core_req, busy);
        end
      end
    end
    core_ack = 1'b1;
    step();
    core_ack = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    checks++;
    if (flags !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got %b, want 10000", flags);
    end
    checks++;
    if (runs_done !== 0 || last_cycles !== 0 || total_cycles !== 0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d/%0d, want 0/0/0", runs_done, last_cycles, total_cycles);
    end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    kick(4'd1);
    checks++;
    if (flags !== 5'b10100) begin
      errors++;
      $display("FAIL single_init: got %b, want 10100", flags);
    end
    wait_req("single");
    finish_run("single", 10);
    checks++;
    if (flags !== 5'b10010) begin
      errors++;
      $display("FAIL single_done: got %b, want 10010", flags);
    end
    checks++;
    if (last_cycles !== 10 || total_cycles !== 10 || runs_done !== 1) begin
      errors++;
      $display("FAIL single_counts: got %0d/%0d/%0d, want 10/10/1", last_cycles, total_cycles, runs_done);
    end
  endtask

  task automatic test_multi();
    kick(4'd3);
    checks++;
    if (runs_done !== 0 || total_cycles !== 0 || last_cycles !== 0 || done !== 1'b0) begin
      errors++;
      $display("FAIL multi_clear: got rd=%0d tot=%0d last=%0d done=%b, want 0/0/0/0",
               runs_done, total_cycles, last_cycles, done);
    end
    wait_req("multi1");
    finish_run("multi1", 5);
    checks++;
    if (runs_done !== 1 || last_cycles !== 5 || flags !== 5'b10100) begin
      errors++;
      $display("FAIL multi_mid: got rd=%0d last=%0d flags=%b, want 1/5/10100", runs_done, last_cycles, flags);
    end
    wait_req("multi2");
    finish_run("multi2", 7);
    wait_req("multi3");
    finish_run("multi3", 9);
    checks++;
    if (total_cycles !== 21 || last_cycles !== 9 || runs_done !== 3 || flags !== 5'b10010) begin
      errors++;
      $display("FAIL multi_end: got tot=%0d last=%0d rd=%0d flags=%b, want 21/9/3/10010",
               total_cycles, last_cycles, runs_done, flags);
    end
  endtask

  task automatic test_watchdog();
    kick(4'd1);
    wait_req("wdog");
    for (int i = 0; i < 16; i++) step();
    checks++;
    if (busy !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL wdog_early: busy=%b fault=%b, want 1/0", busy, fault);
    end
    step();
    checks++;
    if (flags !== 5'b10001 || runs_done !== 0) begin
      errors++;
      $display("FAIL wdog_fault: got %b rd=%0d, want 10001 rd=0", flags, runs_done);
    end
    step();
    checks++;
    if (flags !== 5'b10001) begin
      errors++;
      $display("FAIL wdog_hold: got %b, want 10001", flags);
    end
    host_clear = 1'b1;
    step();
    host_clear = 1'b0;
    checks++;
    if (flags !== 5'b10000) begin
      errors++;
      $display("FAIL wdog_clear: got %b, want 10000", flags);
    end
  endtask

  task automatic test_ack_boundary();
    kick(4'd1);
    wait_req("bound");
    finish_run("bound", 16);
    checks++;
    if (flags !== 5'b10010 || last_cycles !== 16 || total_cycles !== 16) begin
      errors++;
      $display("FAIL bound_ack: got %b last=%0d tot=%0d, want 10010/16/16", flags, last_cycles, total_cycles);
    end
  endtask

  task automatic test_abort();
    kick(4'd2);
    wait_req("abort");
    for (int i = 0; i < 4; i++) step();
    host_abort = 1'b1;
    core_ack   = 1'b1;
    step();
    host_abort = 1'b0;
    core_ack   = 1'b0;
    checks++;
    if (flags !== 5'b10000 || runs_done !== 0 || last_cycles !== 0) begin
      errors++;
      $display("FAIL abort_idle: got %b rd=%0d last=%0d, want 10000/0/0", flags, runs_done, last_cycles);
    end
    kick(4'd0);
    checks++;
    if (flags !== 5'b10010 || runs_done !== 0) begin
      errors++;
      $display("FAIL zero_done: got %b rd=%0d, want 10010/0", flags, runs_done);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (core_req !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL zero_noreq: req=%b done=%b, want 0/1", core_req, done);
      end
    end
  endtask

  task automatic test_stale_ack();
    kick(4'd1);
    // Stale ack and a second start during INIT must both be ignored.
    core_ack   = 1'b1;
    host_start = 1'b1;
    host_runs  = 4'd5;
    wait_req("stale");
    core_ack   = 1'b0;
    host_start = 1'b0;
    finish_run("stale", 3);
    checks++;
    if (flags !== 5'b10010 || runs_done !== 1 || last_cycles !== 3) begin
      errors++;
      $display("FAIL stale_end: got %b rd=%0d last=%0d, want 10010/1/3", flags, runs_done, last_cycles);
    end
  endtask

  task automatic test_reset_mid();
    kick(4'd2);
    wait_req("rmid");
    step();
    step();
    Reset = 1'b1;
    step();
    checks++;
    if (flags !== 5'b10000 || runs_done !== 0 || last_cycles !== 0 || total_cycles !== 0) begin
      errors++;
      $display("FAIL reset_mid: got %b %0d/%0d/%0d, want 10000 0/0/0", flags, runs_done, last_cycles, total_cycles);
    end
    Reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_watchdog();
    test_ack_boundary();
    test_abort();
    test_stale_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
